// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor: sticky pass/fail/timeout checker for riscv-tests completion at DONE_PC
// Ports:
//   clk, rst (async active-low) -- clock and reset
//   pc_valid, pc, gp            -- core PC qualifier, PC, and x3
//   clear                       -- synchronous restart into RUN
//   done, passed, failed, timed_out, test_num, cycles -- registered verdict outputs
module riscv_test_monitor #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] DONE_PC = 32'h0000_0044,
  parameter int TIMEOUT = 5000,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_valid,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  gp,
  input  logic             clear,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [XLEN-1:0]  test_num,
  output logic [CNT_W-1:0] cycles
);
  typedef enum logic [2:0] {IDLE, RUN, PASS, FAIL, TOUT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
  state_t state;
  logic hit, tmo, ok;
  logic [XLEN-1:0] fail_num;
  assign hit = state == RUN && pc_valid && pc == DONE_PC;
  assign tmo = state == RUN && cycles == LAST;
  assign ok = gp == XLEN'(1);
  // even gp means the test never wrote a proper verdict, reported as test 0
  assign fail_num = gp[0] ? gp >> 1 : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      done      <= 1'b0;
      passed    <= 1'b0;
      failed    <= 1'b0;
      timed_out <= 1'b0;
      test_num  <= '0;
      cycles    <= '0;
    end else if (clear) begin
      state     <= RUN;
      done      <= 1'b0;
      passed    <= 1'b0;
      failed    <= 1'b0;
      timed_out <= 1'b0;
      test_num  <= '0;
      cycles    <= '0;
    end else begin
      case (state)
        IDLE: state <= RUN;
        RUN: begin
          cycles <= cycles + CNT_W'(1);
          if (hit) begin
            done     <= 1'b1;
            state    <= ok ? PASS : FAIL;
            passed   <= ok;
            failed   <= !ok;
            test_num <= ok ? '0 : fail_num;
          end else if (tmo) begin
            done      <= 1'b1;
            state     <= TOUT;
            timed_out <= 1'b1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_riscv_test_monitor.sv
// tb_riscv_test_monitor: directed checks of reset, pass/fail/timeout verdicts, clear and async reset
module tb_riscv_test_monitor;
  logic clk = 1'b0;
  logic rst, pc_valid, clear;
  logic [31:0] pc, gp, test_num;
  logic done, passed, failed, timed_out;
  logic [15:0] cycles;
  int errors = 0;
  int checks = 0;

  riscv_test_monitor #(.XLEN(32), .DONE_PC(32'h44), .TIMEOUT(20), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .pc_valid(pc_valid), .pc(pc), .gp(gp), .clear(clear),
    .done(done), .passed(passed), .failed(failed), .timed_out(timed_out),
    .test_num(test_num), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // flags packed as {done, passed, failed, timed_out}
  task automatic check_all(input string tag, input logic [3:0] flg, input logic [31:0] tn, input logic [31:0] cyc);
    check({tag, "/flags"}, {28'b0, done, passed, failed, timed_out}, {28'b0, flg});
    check({tag, "/test_num"}, test_num, tn);
    check({tag, "/cycles"}, {16'b0, cycles}, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic complete(input logic [31:0] g);
    pc_valid = 1'b1;
    pc = 32'h44;
    gp = g;
  endtask

  task automatic idle_bus();
    pc_valid = 1'b0;
    pc = 32'h0;
    gp = 32'h0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear = 1'b0;
    idle_bus();
    #1 check_all("reset_t0", 4'b0000, 0, 0);
    step(3);
    check_all("reset_held", 4'b0000, 0, 0);
    rst = 1'b1;
    step(1);
    check_all("run_start", 4'b0000, 0, 0);
    step(10);
    check_all("run_c10", 4'b0000, 0, 10);
    complete(32'h1);
    step(1);
    check_all("pass", 4'b1100, 0, 11);
    complete(32'h7);
    step(3);
    check_all("pass_sticky", 4'b1100, 0, 11);
    idle_bus();
    pulse_clear();
    check_all("clear_after_pass", 4'b0000, 0, 0);
    step(10);
    complete(32'h7);
    step(1);
    check_all("fail_7", 4'b1010, 3, 11);
    idle_bus();
    pulse_clear();
    step(5);
    complete(32'h4);
    step(1);
    check_all("fail_even_gp", 4'b1010, 0, 6);
    idle_bus();
    pulse_clear();
    pc = 32'h44;
    gp = 32'h1;
    step(5);
    check_all("pc_invalid_ignored", 4'b0000, 0, 5);
    step(14);
    check_all("pre_timeout", 4'b0000, 0, 19);
    step(1);
    check_all("timeout", 4'b1001, 0, 20);
    step(2);
    check_all("timeout_sticky", 4'b1001, 0, 20);
    idle_bus();
    pulse_clear();
    step(19);
    complete(32'h1);
    step(1);
    check_all("completion_beats_timeout", 4'b1100, 0, 20);
    idle_bus();
    pulse_clear();
    step(4);
    check_all("pre_clear_race", 4'b0000, 0, 4);
    clear = 1'b1;
    complete(32'h1);
    step(1);
    clear = 1'b0;
    idle_bus();
    check_all("clear_beats_completion", 4'b0000, 0, 0);
    step(5);
    check_all("run_after_race", 4'b0000, 0, 5);
    complete(32'h9);
    step(1);
    idle_bus();
    check_all("fail_9", 4'b1010, 4, 6);
    pulse_clear();
    step(5);
    #2 rst = 1'b0;
    #1 check_all("async_reset", 4'b0000, 0, 0);
    step(1);
    rst = 1'b1;
    step(1);
    check_all("idle_to_run", 4'b0000, 0, 0);
    step(3);
    complete(32'h1);
    step(1);
    idle_bus();
    check_all("pass_after_reset", 4'b1100, 0, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
